// File: rtl/regalu_sequencer_if.sv
// Instruction delivery bus for regalu_sequencer.
//   instr_in    : 20-bit packed instruction word
//   instr_valid : instr_in is valid this cycle
//   instr_ready : sequencer FIFO can accept a word
//   flush       : synchronous clear of the queued instructions
interface regalu_sequencer_if;
    logic [19:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;

    modport master (
        output instr_in,
        output instr_valid,
        output flush,
        input  instr_ready
    );

    modport slave (
        input  instr_in,
        input  instr_valid,
        input  flush,
        output instr_ready
    );
endinterface

// File: rtl/regalu_sequencer.sv
// Instruction sequencer for the register-file/ALU datapath.
// Buffers instructions in a small FIFO, issues each one through an
// ISSUE (operand settle) / COMMIT (write + result capture) sequence.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ibus              : instruction handshake + flush (slave side)
//   RA1, RA2, WA      : register addresses to the datapath
//   ALUcontrol        : ALU operation code
//   ALUsrc            : 1 selects external_data_in as operand B
//   regwrite          : register-file write enable (COMMIT with wr=1 only)
//   external_data_in  : immediate operand
//   ALUresult         : datapath result (combinational from the above)
//   result            : last captured ALUresult
//   result_valid      : one-cycle pulse when result updates
//   retired           : retired-instruction count, wraps
//   busy              : FSM active or FIFO non-empty
module regalu_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    regalu_sequencer_if.slave ibus,
    output logic [3:0]        RA1,
    output logic [3:0]        RA2,
    output logic [3:0]        WA,
    output logic [1:0]        ALUcontrol,
    output logic              ALUsrc,
    output logic              regwrite,
    output logic signed [7:0] external_data_in,
    input  logic signed [7:0] ALUresult,
    output logic signed [7:0] result,
    output logic              result_valid,
    output logic [7:0]        retired,
    output logic              busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic       alu_src;
        logic       wr;
        logic [3:0] wa;
        logic [3:0] ra1;
        logic [7:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state;
    instr_t          instr_q;
    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next_c;
    logic            ready_q;
    logic            push_c;
    logic            pop_c;

    // Push/pop qualification; flush wins over both.
    always_comb begin
        push_c       = ibus.instr_valid && ready_q && !ibus.flush;
        pop_c        = !ibus.flush && (count != '0) &&
                       ((state == IDLE) || (state == COMMIT));
        count_next_c = ibus.flush ? '0 : (count + CW'(push_c) - CW'(pop_c));
    end

    // FIFO storage (no reset needed, validity is tracked by count).
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= instr_t'(ibus.instr_in);
        end
    end

    // FIFO pointers, count, ready and busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (ibus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_next_c;
            ready_q <= (count_next_c != CW'(DEPTH));
            // Next state is non-IDLE after ISSUE or whenever a pop happens.
            busy    <= (state == ISSUE) || pop_c || (count_next_c != '0);
        end
    end

    // Issue/commit sequencer with registered datapath controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            instr_q      <= '0;
            regwrite     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            retired      <= '0;
        end else begin
            result_valid <= 1'b0;
            regwrite     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        instr_q <= mem[rd_ptr];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    regwrite <= instr_q.wr;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    result       <= ALUresult;
                    result_valid <= 1'b1;
                    retired      <= retired + 8'd1;
                    if (pop_c) begin
                        instr_q <= mem[rd_ptr];
                        state   <= ISSUE;
                    end else begin
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath fields come straight from the instruction register.
    assign ALUcontrol       = instr_q.alu_ctrl;
    assign ALUsrc           = instr_q.alu_src;
    assign WA               = instr_q.wa;
    assign RA1              = instr_q.ra1;
    assign RA2              = instr_q.imm[3:0];
    assign external_data_in = $signed(instr_q.imm);
    assign ibus.instr_ready = ready_q;

endmodule

// File: tb/tb_regalu_sequencer.sv
module tb_regalu_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        RA1, RA2, WA;
    logic [1:0]        ALUcontrol;
    logic              ALUsrc, regwrite, result_valid, busy;
    logic signed [7:0] external_data_in, ALUresult, result;
    logic [7:0]        retired;
    logic              use_fixed;
    logic signed [7:0] fixed_val;
    int                tests_run;
    int                tests_failed;

    regalu_sequencer_if ibus ();

    // Datapath stub: either a fixed value or the immediate passed through.
    assign ALUresult = use_fixed ? fixed_val : external_data_in;

    regalu_sequencer #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ibus             (ibus),
        .RA1              (RA1),
        .RA2              (RA2),
        .WA               (WA),
        .ALUcontrol       (ALUcontrol),
        .ALUsrc           (ALUsrc),
        .regwrite         (regwrite),
        .external_data_in (external_data_in),
        .ALUresult        (ALUresult),
        .result           (result),
        .result_valid     (result_valid),
        .retired          (retired),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [19:0] w);
        ibus.instr_in    = w;
        ibus.instr_valid = 1'b1;
        step();
        ibus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ibus.instr_in = '0; ibus.instr_valid = 1'b0; ibus.flush = 1'b0;
        use_fixed = 1'b1; fixed_val = 8'sd0;
        #12;
        tests_run++; if (ibus.instr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 0", ibus.instr_ready); end
        tests_run++; if ({RA1, RA2, WA, ALUcontrol, ALUsrc, regwrite, external_data_in} !== 23'd0) begin tests_failed++; $display("FAIL reset_datapath: got %0h expected 0", {RA1, RA2, WA, ALUcontrol, ALUsrc, regwrite, external_data_in}); end
        tests_run++; if ({result, result_valid, retired, busy} !== 18'd0) begin tests_failed++; $display("FAIL reset_status: got %0h expected 0", {result, result_valid, retired, busy}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        tests_run++; if (ibus.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %0b expected 1", ibus.instr_ready); end
    endtask

    task automatic test_single_write();
        use_fixed = 1'b1; fixed_val = 8'sh2A;
        push_word(20'h3502A);
        step(); // ISSUE
        tests_run++; if ({RA1, WA, ALUcontrol, ALUsrc} !== {4'h0, 4'h5, 2'b00, 1'b1}) begin tests_failed++; $display("FAIL single_issue_fields: got %0h expected %0h", {RA1, WA, ALUcontrol, ALUsrc}, {4'h0, 4'h5, 2'b00, 1'b1}); end
        tests_run++; if (external_data_in !== 8'sh2A) begin tests_failed++; $display("FAIL single_issue_imm: got %0h expected 2a", external_data_in); end
        tests_run++; if ({regwrite, result_valid} !== 2'b00) begin tests_failed++; $display("FAIL single_issue_we: got %0b expected 00", {regwrite, result_valid}); end
        step(); // COMMIT
        tests_run++; if ({regwrite, result_valid} !== 2'b10) begin tests_failed++; $display("FAIL single_commit_we: got %0b expected 10", {regwrite, result_valid}); end
        step(); // three cycles after accept
        tests_run++; if ({result_valid, regwrite} !== 2'b10) begin tests_failed++; $display("FAIL single_result_pulse: got %0b expected 10", {result_valid, regwrite}); end
        tests_run++; if (result !== 8'sh2A) begin tests_failed++; $display("FAIL single_result: got %0h expected 2a", result); end
        tests_run++; if (retired !== 8'd1) begin tests_failed++; $display("FAIL single_retired: got %0d expected 1", retired); end
        step();
        tests_run++; if ({result_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL single_idle: got %0b expected 00", {result_valid, busy}); end
        tests_run++; if (WA !== 4'h5) begin tests_failed++; $display("FAIL single_hold_wa: got %0h expected 5", WA); end
    endtask

    task automatic test_reg_reg();
        use_fixed = 1'b1; fixed_val = -8'sd5;
        push_word(20'h80123);
        step(); // ISSUE
        tests_run++; if ({ALUcontrol, ALUsrc, RA1, RA2} !== {2'b10, 1'b0, 4'h1, 4'h3}) begin tests_failed++; $display("FAIL rr_issue_fields: got %0h expected %0h", {ALUcontrol, ALUsrc, RA1, RA2}, {2'b10, 1'b0, 4'h1, 4'h3}); end
        tests_run++; if (regwrite !== 1'b0) begin tests_failed++; $display("FAIL rr_issue_we: got %0b expected 0", regwrite); end
        step(); // COMMIT
        tests_run++; if (regwrite !== 1'b0) begin tests_failed++; $display("FAIL rr_commit_we: got %0b expected 0", regwrite); end
        step();
        tests_run++; if ({result_valid, result} !== {1'b1, 8'hFB}) begin tests_failed++; $display("FAIL rr_result: got %0h expected 1fb", {result_valid, result}); end
        tests_run++; if (retired !== 8'd2) begin tests_failed++; $display("FAIL rr_retired: got %0d expected 2", retired); end
        step();
    endtask

    task automatic test_back_to_back();
        logic       exp_ready [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_res   [8]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h18};
        int         idx = 0;
        logic       rv_exp, we_exp;
        use_fixed = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k < 10) begin
                ibus.instr_in    = {2'b00, 1'b1, 1'b1, 4'(k), 4'h0, 8'h10 + 8'(k)};
                ibus.instr_valid = 1'b1;
            end else begin
                ibus.instr_valid = 1'b0;
            end
            step();
            if (k < 10) begin
                tests_run++; if (ibus.instr_ready !== exp_ready[k]) begin tests_failed++; $display("FAIL b2b_ready[%0d]: got %0b expected %0b", k, ibus.instr_ready, exp_ready[k]); end
            end
            rv_exp = (k >= 3) && (k % 2 == 1);
            we_exp = (k >= 2) && (k <= 16) && (k % 2 == 0);
            tests_run++; if (result_valid !== rv_exp) begin tests_failed++; $display("FAIL b2b_valid[%0d]: got %0b expected %0b", k, result_valid, rv_exp); end
            tests_run++; if (regwrite !== we_exp) begin tests_failed++; $display("FAIL b2b_we[%0d]: got %0b expected %0b", k, regwrite, we_exp); end
            tests_run++; if (busy !== (k < 17)) begin tests_failed++; $display("FAIL b2b_busy[%0d]: got %0b expected %0b", k, busy, (k < 17)); end
            if (rv_exp && idx < 8) begin
                tests_run++; if (result !== exp_res[idx]) begin tests_failed++; $display("FAIL b2b_order[%0d]: got %0h expected %0h", idx, result, exp_res[idx]); end
                idx++;
            end
        end
        tests_run++; if (retired !== 8'd10) begin tests_failed++; $display("FAIL b2b_retired: got %0d expected 10", retired); end
    endtask

    task automatic test_flush();
        use_fixed = 1'b0;
        push_word(20'h35021);
        push_word(20'h35022); // first instruction now in ISSUE
        ibus.instr_in = 20'h35023; ibus.instr_valid = 1'b1; ibus.flush = 1'b1;
        step();
        ibus.instr_valid = 1'b0; ibus.flush = 1'b0;
        tests_run++; if ({busy, regwrite, external_data_in} !== {1'b1, 1'b1, 8'h21}) begin tests_failed++; $display("FAIL flush_commit: got %0h expected 321", {busy, regwrite, external_data_in}); end
        step();
        tests_run++; if ({result_valid, result} !== {1'b1, 8'h21}) begin tests_failed++; $display("FAIL flush_first_retires: got %0h expected 121", {result_valid, result}); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy: got %0b expected 0", busy); end
        step(); step(); step();
        tests_run++; if ({result_valid, retired, external_data_in} !== {1'b0, 8'd11, 8'h21}) begin tests_failed++; $display("FAIL flush_dropped: got %0h expected %0h", {result_valid, retired, external_data_in}, {1'b0, 8'd11, 8'h21}); end
        tests_run++; if (ibus.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %0b expected 1", ibus.instr_ready); end
    endtask

    task automatic test_reset_commit();
        use_fixed = 1'b0;
        push_word(20'h37033);
        step(); // ISSUE
        step(); // COMMIT
        tests_run++; if (regwrite !== 1'b1) begin tests_failed++; $display("FAIL rstc_commit_we: got %0b expected 1", regwrite); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (regwrite !== 1'b0) begin tests_failed++; $display("FAIL rstc_async_we: got %0b expected 0", regwrite); end
        tests_run++; if ({result_valid, retired, busy} !== 10'd0) begin tests_failed++; $display("FAIL rstc_status: got %0h expected 0", {result_valid, retired, busy}); end
        step(); step();
        rst_n = 1'b1;
        step();
        tests_run++; if ({ibus.instr_ready, retired, result} !== {1'b1, 8'd0, 8'h00}) begin tests_failed++; $display("FAIL rstc_release: got %0h expected 10000", {ibus.instr_ready, retired, result}); end
        step(); step();
        tests_run++; if ({result_valid, regwrite, busy} !== 3'b000) begin tests_failed++; $display("FAIL rstc_no_pulse: got %0b expected 000", {result_valid, regwrite, busy}); end
    endtask

    task automatic test_counter_wrap();
        use_fixed = 1'b0;
        for (int i = 0; i < 256; i++) begin
            push_word({2'b01, 1'b1, 1'b0, 4'h2, 4'h4, 8'(i)});
            step(); step(); step();
            if (i == 254) begin
                tests_run++; if (retired !== 8'd255) begin tests_failed++; $display("FAIL wrap_255: got %0d expected 255", retired); end
            end
        end
        tests_run++; if (retired !== 8'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d expected 0", retired); end
        tests_run++; if ({result_valid, result} !== {1'b1, 8'hFF}) begin tests_failed++; $display("FAIL wrap_last_result: got %0h expected 1ff", {result_valid, result}); end
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_write();
        test_reg_reg();
        test_back_to_back();
        test_flush();
        test_reset_commit();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
